// File: rtl/reg_file_pkg.sv
// Shared sizing and read-port state encoding for the MyProc2 register file.
package reg_file_pkg;

    localparam int WIDTH        = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int NUM_REGS     = 2 ** REG_ADDR_LEN;
    localparam int NUM_RD_PORTS = 2;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_RESP = 2'd1,
        PS_WAIT = 2'd2
    } port_state_t;

endpackage

// File: rtl/reg_read_port.sv
// One read-port responder: answers immediately when the register is ready,
// otherwise parks on the address until writeback delivers it.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int AW = REG_ADDR_LEN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_en,
    input  logic [W-1:0]  rd_value,
    input  logic          rd_pending,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          wr_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_st,
    output logic          busy
);

    port_state_t   state, state_nx;
    logic [AW-1:0] lat_addr, lat_addr_nx;
    logic [W-1:0]  data_nx;
    logic          rd_hit, lat_hit;

    // r0 is never a real write target, so it can never bypass
    assign rd_hit  = wr_en && (wr_addr == rd_addr) && (rd_addr != '0);
    // a parked address is never r0, no zero guard needed
    assign lat_hit = wr_en && (wr_addr == lat_addr);

    always_comb begin
        state_nx    = state;
        lat_addr_nx = lat_addr;
        data_nx     = rd_data;
        case (state)
            PS_WAIT: begin
                if (lat_hit) begin
                    state_nx = PS_RESP;
                    data_nx  = wr_data;
                end
            end
            default: begin
                // RESP accepts a new request exactly like IDLE
                state_nx = PS_IDLE;
                if (rd_en) begin
                    if (rd_addr == '0) begin
                        state_nx = PS_RESP;
                        data_nx  = '0;
                    end else if (rd_hit) begin
                        state_nx = PS_RESP;
                        data_nx  = wr_data;
                    end else if (!rd_pending) begin
                        state_nx = PS_RESP;
                        data_nx  = rd_value;
                    end else begin
                        state_nx    = PS_WAIT;
                        lat_addr_nx = rd_addr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= PS_IDLE;
            lat_addr <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            lat_addr <= lat_addr_nx;
            rd_data  <= data_nx;
        end
    end

    assign rd_st = (state == PS_RESP);
    assign busy  = (state == PS_WAIT);

endmodule

// File: rtl/reg_file.sv
// 32-entry register file with pending scoreboard, two blocking read ports
// and one writeback port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH        = reg_file_pkg::WIDTH,
    parameter int REG_ADDR_LEN = reg_file_pkg::REG_ADDR_LEN,
    parameter int NUM_REGS     = 2 ** REG_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REG_ADDR_LEN-1:0] Rd1_addr,
    input  logic                    Rd1_en,
    output logic [WIDTH-1:0]        Rd1_data,
    output logic                    Rd1_st,
    input  logic [REG_ADDR_LEN-1:0] Rd2_addr,
    input  logic                    Rd2_en,
    output logic [WIDTH-1:0]        Rd2_data,
    output logic                    Rd2_st,
    input  logic [REG_ADDR_LEN-1:0] Wr_addr,
    input  logic [WIDTH-1:0]        Wr_data,
    input  logic                    Wr_en,
    input  logic [REG_ADDR_LEN-1:0] Rsv_addr,
    input  logic                    Rsv_en,
    output logic                    Busy
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            pending;

    logic [NUM_RD_PORTS-1:0][REG_ADDR_LEN-1:0] rd_addr;
    logic [NUM_RD_PORTS-1:0]                   rd_en;
    logic [NUM_RD_PORTS-1:0][WIDTH-1:0]        rd_data;
    logic [NUM_RD_PORTS-1:0]                   rd_st;
    logic [NUM_RD_PORTS-1:0]                   port_busy;

    assign rd_addr = {Rd2_addr, Rd1_addr};
    assign rd_en   = {Rd2_en, Rd1_en};

    // r0 is never written and never reserved, so it stays zero and ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            if (Wr_en && (Wr_addr != '0)) begin
                regs[Wr_addr]    <= Wr_data;
                pending[Wr_addr] <= 1'b0;
            end
            // later assignment: reserve wins over a same-cycle write clear
            if (Rsv_en && (Rsv_addr != '0))
                pending[Rsv_addr] <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
        reg_read_port #(
            .W  (WIDTH),
            .AW (REG_ADDR_LEN)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_addr    (rd_addr[gi]),
            .rd_en      (rd_en[gi]),
            .rd_value   (regs[rd_addr[gi]]),
            .rd_pending (pending[rd_addr[gi]]),
            .wr_addr    (Wr_addr),
            .wr_data    (Wr_data),
            .wr_en      (Wr_en),
            .rd_data    (rd_data[gi]),
            .rd_st      (rd_st[gi]),
            .busy       (port_busy[gi])
        );
    end

    assign Rd1_data = rd_data[0];
    assign Rd2_data = rd_data[1];
    assign Rd1_st   = rd_st[0];
    assign Rd2_st   = rd_st[1];
    assign Busy     = |port_busy;

endmodule

// File: tb/tb_reg_file.sv
// Directed scenarios followed by random traffic, every cycle compared
// against an architectural model of registers, scoreboard and requests.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rd1_addr, Rd2_addr, Wr_addr, Rsv_addr;
    logic        Rd1_en, Rd2_en, Wr_en, Rsv_en;
    logic [31:0] Wr_data, Rd1_data, Rd2_data;
    logic        Rd1_st, Rd2_st, Busy;

    int checks = 0;
    int errors = 0;

    // model: architectural contents, outstanding-producer flags, and per
    // port the register a request is parked on (-1 = none) plus last answer
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          m_park [2];
    bit          m_st   [2];
    logic [31:0] m_data [2];

    always #5 clk = ~clk;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Rd1_addr (Rd1_addr),
        .Rd1_en   (Rd1_en),
        .Rd1_data (Rd1_data),
        .Rd1_st   (Rd1_st),
        .Rd2_addr (Rd2_addr),
        .Rd2_en   (Rd2_en),
        .Rd2_data (Rd2_data),
        .Rd2_st   (Rd2_st),
        .Wr_addr  (Wr_addr),
        .Wr_data  (Wr_data),
        .Wr_en    (Wr_en),
        .Rsv_addr (Rsv_addr),
        .Rsv_en   (Rsv_en),
        .Busy     (Busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        Rd1_en = 0; Rd2_en = 0; Wr_en = 0; Rsv_en = 0;
        Rd1_addr = 0; Rd2_addr = 0; Wr_addr = 0; Rsv_addr = 0; Wr_data = 0;
    endtask

    // what one clock edge does to the architectural state, given current inputs
    task automatic model_edge();
        logic [4:0]  a;
        bit          en;
        bit          wr_real;
        wr_real = Wr_en && (Wr_addr != 0);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin m_mem[i] = 0; m_pend[i] = 0; end
            for (int p = 0; p < 2; p++) begin m_park[p] = -1; m_st[p] = 0; m_data[p] = 0; end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            a  = (p == 0) ? Rd1_addr : Rd2_addr;
            en = (p == 0) ? Rd1_en : Rd2_en;
            m_st[p] = 0;
            if (m_park[p] >= 0) begin
                if (wr_real && (int'(Wr_addr) == m_park[p])) begin
                    m_st[p] = 1; m_data[p] = Wr_data; m_park[p] = -1;
                end
            end else if (en) begin
                if (a == 0) begin
                    m_st[p] = 1; m_data[p] = 0;
                end else if (wr_real && Wr_addr == a) begin
                    m_st[p] = 1; m_data[p] = Wr_data;
                end else if (!m_pend[a]) begin
                    m_st[p] = 1; m_data[p] = m_mem[a];
                end else begin
                    m_park[p] = a;
                end
            end
        end
        if (wr_real) begin m_mem[Wr_addr] = Wr_data; m_pend[Wr_addr] = 0; end
        if (Rsv_en && Rsv_addr != 0) m_pend[Rsv_addr] = 1;
    endtask

    // apply current inputs for one edge, then compare every output
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("rd1_st",   {31'd0, Rd1_st}, {31'd0, m_st[0]});
        chk("rd1_data", Rd1_data, m_data[0]);
        chk("rd2_st",   {31'd0, Rd2_st}, {31'd0, m_st[1]});
        chk("rd2_data", Rd2_data, m_data[1]);
        chk("busy",     {31'd0, Busy}, {31'd0, (m_park[0] >= 0) || (m_park[1] >= 0)});
    endtask

    initial begin
        for (int p = 0; p < 2; p++) m_park[p] = -1;
        idle();
        rst_n = 0;
        cyc(); cyc();
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_rd1_data", Rd1_data, 32'd0);
        rst_n = 1;

        // write r5 then read it, r0 on the other port
        Wr_en = 1; Wr_addr = 5; Wr_data = 32'h1234; cyc(); idle();
        Rd1_en = 1; Rd1_addr = 5; Rd2_en = 1; Rd2_addr = 0; cyc(); idle();
        chk("r5_st", {31'd0, Rd1_st}, 32'd1);
        chk("r5_data", Rd1_data, 32'h1234);
        chk("r0_p2", Rd2_data, 32'd0);

        // r0 ignores writes and reservations
        Wr_en = 1; Wr_addr = 0; Wr_data = 32'hFFFF; cyc(); idle();
        Rd1_en = 1; Rd1_addr = 0; cyc(); idle();
        chk("r0_write_dropped", Rd1_data, 32'd0);
        Rsv_en = 1; Rsv_addr = 0; cyc(); idle();
        Rd1_en = 1; Rd1_addr = 0; cyc(); idle();
        chk("r0_rsv_nowait", {31'd0, Rd1_st}, 32'd1);

        // wait on r7 until writeback
        Rsv_en = 1; Rsv_addr = 7; cyc(); idle();
        Rd1_en = 1; Rd1_addr = 7; cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            chk("r7_busy", {31'd0, Busy}, 32'd1);
            chk("r7_nostrobe", {31'd0, Rd1_st}, 32'd0);
            cyc();
        end
        Wr_en = 1; Wr_addr = 7; Wr_data = 32'hABCD; cyc(); idle();
        chk("r7_st", {31'd0, Rd1_st}, 32'd1);
        chk("r7_data", Rd1_data, 32'hABCD);
        chk("r7_busy_clr", {31'd0, Busy}, 32'd0);
        cyc();

        // same-cycle write bypass
        Wr_en = 1; Wr_addr = 3; Wr_data = 32'h11; cyc(); idle();
        Wr_en = 1; Wr_addr = 3; Wr_data = 32'h55; Rd2_en = 1; Rd2_addr = 3; cyc(); idle();
        chk("r3_bypass", Rd2_data, 32'h55);

        // both ports parked on r9, released together; reserve beats write
        Rsv_en = 1; Rsv_addr = 9; cyc(); idle();
        Rd1_en = 1; Rd1_addr = 9; Rd2_en = 1; Rd2_addr = 9; cyc(); idle();
        cyc();
        Wr_en = 1; Wr_addr = 9; Wr_data = 32'h99; Rsv_en = 1; Rsv_addr = 9; cyc(); idle();
        chk("r9_both_st", {30'd0, Rd2_st, Rd1_st}, 32'd3);
        chk("r9_p1", Rd1_data, 32'h99);
        chk("r9_p2", Rd2_data, 32'h99);
        Rd1_en = 1; Rd1_addr = 9; cyc(); idle();
        chk("r9_still_pending", {31'd0, Busy}, 32'd1);

        // reset while parked
        rst_n = 0; cyc(); rst_n = 1;
        chk("rst_wait_busy", {31'd0, Busy}, 32'd0);
        chk("rst_wait_st", {31'd0, Rd1_st}, 32'd0);
        cyc();
        Rd1_en = 1; Rd1_addr = 9; cyc(); idle();
        chk("r9_after_rst", Rd1_data, 32'd0);

        // random traffic on a narrow address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(199) != 0);
            Rd1_en   = $urandom_range(1);
            Rd2_en   = $urandom_range(1);
            Rd1_addr = 5'($urandom_range(7));
            Rd2_addr = 5'($urandom_range(7));
            Wr_en    = ($urandom_range(2) == 0);
            Wr_addr  = 5'($urandom_range(7));
            Wr_data  = $urandom;
            Rsv_en   = ($urandom_range(3) == 0);
            Rsv_addr = 5'($urandom_range(7));
            cyc();
        end
        rst_n = 1;
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Register file for the MyProc2 pipeline: 32 registers of `WIDTH` bits with two read ports, one write port, and a per-register pending scoreboard. It is the responder side of the decode stage's read handshake (`RdN_addr`/`RdN_en` in, `RdN_data`/`RdN_st` out) and the sink of the writeback stage. A read of a register with an outstanding producer is held until writeback delivers the value, then answered with a one-cycle strobe.

## Interface
- `WIDTH`, 32, data width (from params.v)
- `REG_ADDR_LEN`, 5, register address width (from params.v)
- `NUM_REGS`, 32, register count, equal to 2**`REG_ADDR_LEN`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `Rd1_addr`  in  `REG_ADDR_LEN`  read port 1 address
- `Rd1_en`  in  1  read port 1 request, sampled at posedge
- `Rd1_data`  out  `WIDTH`  read port 1 data, valid while `Rd1_st`=1, held afterwards
- `Rd1_st`  out  1  read port 1 response strobe, one-cycle pulse
- `Rd2_addr`, `Rd2_en`, `Rd2_data`, `Rd2_st`  as port 1
- `Wr_addr`  in  `REG_ADDR_LEN`  writeback address
- `Wr_data`  in  `WIDTH`  writeback data
- `Wr_en`  in  1  writeback strobe
- `Rsv_addr`  in  `REG_ADDR_LEN`  destination register being issued
- `Rsv_en`  in  1  mark `Rsv_addr` pending
- `Busy`  out  1  OR of both ports in WAIT

## Operation
- Reset (`rst_n`=0 at posedge): all registers 0, all pending bits 0, `RdN_st`=0, `RdN_data`=0, both ports IDLE, `Busy`=0.
- Register 0 reads as 0 always. Writes to r0 are discarded. Reservations of r0 are ignored. Reads of r0 never wait.
- Write: `Wr_en` at posedge stores `Wr_data` at `Wr_addr` and clears its pending bit.
- Reserve: `Rsv_en` sets the pending bit of `Rsv_addr`. If reserve and write target the same address in the same cycle, the reserve wins and the bit ends set. The write data is still stored.
- Per-port FSM, identical for both ports:
  - IDLE: on `RdN_en`:
    - If the address is not pending, or is written this cycle, go to RESP.
    - Otherwise latch the address and go to WAIT.
  - RESP (one cycle): `RdN_st`=1 with data, then go to IDLE. A new `RdN_en` in this cycle is accepted as if in IDLE (back-to-back reads).
  - WAIT: `RdN_en` is ignored. Leave WAIT on the cycle `Wr_en`=1 with `Wr_addr` equal to the latched address; take `Wr_data` and go to RESP.
- Bypass: a read of an address being written in the same cycle returns `Wr_data`, not the old contents.
- The pending check uses the bit value before this cycle's reserve. A read and a reserve of the same address in the same cycle reads the current value and does not wait (the reserving instruction is younger).
- Both ports operate independently. Both may wait on the same address and are released together.

## Timing
- Read latency from `RdN_en` to `RdN_st` is 1 cycle when not pending.
- When pending, `RdN_st` rises the cycle after the matching `Wr_en`.
- `RdN_st` is high for exactly one cycle per accepted request.
- `RdN_data` is registered. It changes only in the cycle `RdN_st` rises.
- `Busy` is registered and high for every cycle a port is in WAIT.
- Reset asserted mid-WAIT or mid-RESP returns the port to IDLE next edge with no strobe.

## Structure
- params.v holds `WIDTH`, `REG_ADDR_LEN` and `NUM_REGS`.
- ISA.v is not needed.
- One sub-module, `reg_read_port`, instantiated twice. It holds the IDLE/RESP/WAIT FSM, the latched address, and the data/strobe registers. Its inputs are the storage read value, the pending bit, and the write bus.
- Storage array, pending vector and write/reserve logic live in `reg_file`.

## Test plan
- Reset, write r5=0x1234 → `Rd1` of r5 one cycle later gives `Rd1_st` pulse with 0x1234. `Rd2` of r0 gives 0.
- Write r0=0xFFFF, then read r0 → 0. `Rsv_en` r0, then read r0 → no wait, strobe after 1 cycle.
- `Rsv_en` r7, then `Rd1_en` r7 → `Busy`=1, no strobe for 4 cycles. `Wr_en` r7=0xABCD → `Rd1_st` next cycle with 0xABCD, `Busy`=0.
- Same cycle `Wr_en` r3=0x55 and `Rd2_en` r3 (old value 0x11) → `Rd2_data`=0x55.
- Both ports wait on r9. `Wr_en` r9=0x99 → both strobes in the same cycle with 0x99. Simultaneous `Rsv_en`+`Wr_en` on r9 → r9 remains pending.
- Port 1 in WAIT, `rst_n`=0 one cycle → port IDLE, `Rd1_st` never pulses, r9 reads 0.
